// File: rtl/ddr2_pkg.sv
// Shared definitions for the DDR2 port scheduler slice.
// Holds the scheduler state encoding, the default widths/depths used as
// parameter defaults, and the grant identifiers for the round-robin.
package ddr2_pkg;

  localparam int unsigned ADDR_W_DEF   = 24;
  localparam int unsigned LEN_W_DEF    = 7;
  localparam int unsigned LVL_W_DEF    = 10;
  localparam int unsigned RD_DEPTH_DEF = 512;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_CMD,
    RD_WAIT
  } state_t;

  localparam logic GNT_WR = 1'b0;
  localparam logic GNT_RD = 1'b1;

endpackage

// File: rtl/ddr2_addr_gen.sv
// Per-port burst address counter.
// Advances by one burst at burst end and wraps to minaddr when the following
// burst would not fit below maxaddr. A load request is held pending: it
// rewinds immediately when the port is idle, otherwise at the burst end,
// where it replaces the advance.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   minaddr, maxaddr  address window [minaddr, maxaddr)
//   size              burst length of the burst in flight
//   load              rewind request (captured into a pending flag)
//   in_flight         this port currently owns a burst
//   burst_end         the port's burst completes this cycle
//   addr              current burst start address
module ddr2_addr_gen
  import ddr2_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] minaddr,
  input  logic [ADDR_W-1:0] maxaddr,
  input  logic [LEN_W-1:0]  size,
  input  logic              load,
  input  logic              in_flight,
  input  logic              burst_end,
  output logic [ADDR_W-1:0] addr
);

  localparam int unsigned PAD = ADDR_W + 1 - LEN_W;

  logic              pending;
  logic              pend_any;
  logic [ADDR_W:0]   next_ext;
  logic [ADDR_W:0]   limit_ext;

  // One extra bit so the end-of-next-burst compare cannot overflow.
  always_comb begin
    pend_any  = pending | load;
    next_ext  = {1'b0, addr} + {{PAD{1'b0}}, size};
    limit_ext = next_ext + {{PAD{1'b0}}, size};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= '0;
      pending <= 1'b0;
    end else if (burst_end) begin
      pending <= 1'b0;
      if (pend_any)
        addr <= minaddr;
      else if (limit_ext > {1'b0, maxaddr})
        addr <= minaddr;
      else
        addr <= next_ext[ADDR_W-1:0];
    end else if (pend_any && !in_flight) begin
      addr    <= minaddr;
      pending <= 1'b0;
    end else begin
      pending <= pend_any;
    end
  end

endmodule

// File: rtl/ddr2_port_scheduler.sv
// DDR2 local-interface scheduler for one write FIFO and one read FIFO.
// Round-robins whole bursts between the write and read ports and issues the
// controller's local_* handshake for each burst.
// Ports:
//   clk, rst                      phy clock, synchronous active-high reset
//   init_done                     controller calibration complete
//   burst_len                     words per burst (0 parks the scheduler)
//   wr_/rd_minaddr, _maxaddr      per-port address windows
//   wr_load, rd_load              rewind a port to its minaddr
//   wr_fifo_used, rd_fifo_used    FIFO fill levels
//   wr_fifo_rden, rd_fifo_wren    FIFO pop / push strobes
//   local_*                       controller local interface
//   busy                          a burst is in flight
module ddr2_port_scheduler
  import ddr2_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned LEN_W    = LEN_W_DEF,
  parameter int unsigned LVL_W    = LVL_W_DEF,
  parameter int unsigned RD_DEPTH = RD_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [ADDR_W-1:0] wr_minaddr,
  input  logic [ADDR_W-1:0] wr_maxaddr,
  input  logic [ADDR_W-1:0] rd_minaddr,
  input  logic [ADDR_W-1:0] rd_maxaddr,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic [LVL_W-1:0]  wr_fifo_used,
  input  logic [LVL_W-1:0]  rd_fifo_used,
  output logic              wr_fifo_rden,
  output logic              rd_fifo_wren,
  input  logic              local_ready,
  input  logic              local_rdata_valid,
  output logic [ADDR_W-1:0] local_address,
  output logic [LEN_W-1:0]  local_size,
  output logic              local_burstbegin,
  output logic              local_write_req,
  output logic              local_read_req,
  output logic              busy
);

  localparam logic [LVL_W:0] DEPTH_V = RD_DEPTH[LVL_W:0];

  state_t            state, state_nxt;
  logic              last_gnt, last_gnt_nxt;
  logic [LEN_W-1:0]  size_q, size_nxt;
  logic [LEN_W-1:0]  cnt, cnt_nxt;
  logic              first, first_nxt;
  logic              wr_ok, rd_ok;
  logic              wr_end, rd_end;
  logic [LVL_W:0]    rd_free;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  always_comb begin
    rd_free = DEPTH_V - {1'b0, rd_fifo_used};
    wr_ok   = init_done && (burst_len != '0) &&
              (wr_fifo_used >= {{(LVL_W-LEN_W){1'b0}}, burst_len});
    rd_ok   = init_done && (burst_len != '0) &&
              (rd_free >= {{(LVL_W+1-LEN_W){1'b0}}, burst_len});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= GNT_RD;
      size_q   <= '0;
      cnt      <= '0;
      first    <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      size_q   <= size_nxt;
      cnt      <= cnt_nxt;
      first    <= first_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    last_gnt_nxt     = last_gnt;
    size_nxt         = size_q;
    cnt_nxt          = cnt;
    first_nxt        = first;
    wr_end           = 1'b0;
    rd_end           = 1'b0;
    local_write_req  = 1'b0;
    local_read_req   = 1'b0;
    local_burstbegin = 1'b0;
    local_address    = '0;
    unique case (state)
      IDLE: begin
        // Write wins a tie only if read had the previous grant.
        if (wr_ok && (!rd_ok || last_gnt == GNT_RD)) begin
          state_nxt    = WR;
          last_gnt_nxt = GNT_WR;
          size_nxt     = burst_len;
          cnt_nxt      = '0;
          first_nxt    = 1'b1;
        end else if (rd_ok) begin
          state_nxt    = RD_CMD;
          last_gnt_nxt = GNT_RD;
          size_nxt     = burst_len;
          cnt_nxt      = '0;
        end
      end
      WR: begin
        local_write_req  = 1'b1;
        local_burstbegin = first;
        local_address    = wr_addr;
        if (local_ready) begin
          first_nxt = 1'b0;
          cnt_nxt   = cnt + 1'b1;
          if (cnt + 1'b1 == size_q) begin
            wr_end    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      RD_CMD: begin
        local_read_req   = 1'b1;
        local_burstbegin = 1'b1;
        local_address    = rd_addr;
        if (local_ready) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        local_address = rd_addr;
        if (local_rdata_valid) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt + 1'b1 == size_q) begin
            rd_end    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_fifo_rden = local_write_req & local_ready;
  assign rd_fifo_wren = local_rdata_valid;
  assign local_size   = size_q;
  assign busy         = (state != IDLE);

  ddr2_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wr_addr (
    .clk       (clk),
    .rst       (rst),
    .minaddr   (wr_minaddr),
    .maxaddr   (wr_maxaddr),
    .size      (size_q),
    .load      (wr_load),
    .in_flight (state == WR),
    .burst_end (wr_end),
    .addr      (wr_addr)
  );

  ddr2_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd_addr (
    .clk       (clk),
    .rst       (rst),
    .minaddr   (rd_minaddr),
    .maxaddr   (rd_maxaddr),
    .size      (size_q),
    .load      (rd_load),
    .in_flight ((state == RD_CMD) || (state == RD_WAIT)),
    .burst_end (rd_end),
    .addr      (rd_addr)
  );

endmodule

// File: tb/tb_ddr2_port_scheduler.sv
// Self-checking bench for ddr2_port_scheduler: eligibility vector table,
// hand sequences for burst/wrap/load/reset corners, and randomized traffic
// against a burst-level reference model.
module tb_ddr2_port_scheduler;

  localparam int AW = 24;
  localparam int LW = 7;
  localparam int VW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done;
  logic [LW-1:0] burst_len;
  logic [AW-1:0] wr_minaddr, wr_maxaddr, rd_minaddr, rd_maxaddr;
  logic          wr_load, rd_load;
  logic [VW-1:0] wr_fifo_used, rd_fifo_used;
  logic          wr_fifo_rden, rd_fifo_wren;
  logic          local_ready, local_rdata_valid;
  logic [AW-1:0] local_address;
  logic [LW-1:0] local_size;
  logic          local_burstbegin, local_write_req, local_read_req, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr2_port_scheduler #(.ADDR_W(AW), .LEN_W(LW), .LVL_W(VW), .RD_DEPTH(512)) dut (
    .clk               (clk),
    .rst               (rst),
    .init_done         (init_done),
    .burst_len         (burst_len),
    .wr_minaddr        (wr_minaddr),
    .wr_maxaddr        (wr_maxaddr),
    .rd_minaddr        (rd_minaddr),
    .rd_maxaddr        (rd_maxaddr),
    .wr_load           (wr_load),
    .rd_load           (rd_load),
    .wr_fifo_used      (wr_fifo_used),
    .rd_fifo_used      (rd_fifo_used),
    .wr_fifo_rden      (wr_fifo_rden),
    .rd_fifo_wren      (rd_fifo_wren),
    .local_ready       (local_ready),
    .local_rdata_valid (local_rdata_valid),
    .local_address     (local_address),
    .local_size        (local_size),
    .local_burstbegin  (local_burstbegin),
    .local_write_req   (local_write_req),
    .local_read_req    (local_read_req),
    .busy              (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_wreq"}, 32'(local_write_req), 0);
    chk({name, "_rreq"}, 32'(local_read_req), 0);
    chk({name, "_bb"},   32'(local_burstbegin), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_rden"}, 32'(wr_fifo_rden), 0);
    chk({name, "_wren"}, 32'(rd_fifo_wren), 0);
    chk({name, "_addr"}, 32'(local_address), 0);
    chk({name, "_size"}, 32'(local_size), 0);
  endtask

  // Leaves the bench on a negedge with rst just released; outputs still show reset state.
  task automatic do_reset();
    rst = 1'b1; wr_load = 1'b0; rd_load = 1'b0;
    local_ready = 1'b1; local_rdata_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [AW-1:0] adv(input logic [AW-1:0] a, input logic [AW-1:0] mn,
                                        input logic [AW-1:0] mx, input int unsigned len);
    longint n;
    n = longint'(a) + longint'(len);
    if (n + longint'(len) > longint'(mx)) return mn;
    return AW'(n);
  endfunction

  // Runs one write burst. evt: 0 none, 1 wr_load after 10 beats, 2 rst after 10 beats.
  int b_beats, b_bb, b_late_bb, b_unstable, b_ok;
  logic [AW-1:0] b_addr;
  task automatic run_wr_burst(input int toggle, input int evt);
    int cyc;
    cyc = 0; b_beats = 0; b_bb = 0; b_late_bb = 0; b_unstable = 0; b_ok = 1;
    while (!local_write_req && cyc < 200) begin @(negedge clk); cyc++; end
    if (!local_write_req) begin
      chk("wr_burst_start_timeout", 0, 1);
      b_ok = 0;
      return;
    end
    b_addr = local_address;
    while (local_write_req && cyc < 2000) begin
      local_ready = (toggle != 0) ? ((cyc % 2) == 0) : 1'b1;
      wr_load     = (evt == 1 && b_beats == 10);
      rst         = (evt == 2 && b_beats == 10);
      #1;
      if (local_address !== b_addr) b_unstable++;
      if (local_burstbegin && b_beats > 0) b_late_bb++;
      if (local_burstbegin && local_ready) b_bb++;
      if (wr_fifo_rden) b_beats++;
      if (rst) break;
      @(negedge clk); cyc++;
    end
    wr_load = 1'b0;
    local_ready = 1'b1;
  endtask

  typedef struct {
    logic          init;
    logic [LW-1:0] len;
    logic [VW-1:0] wu;
    logic [VW-1:0] ru;
    logic          ew;
    logic          er;
  } vec_t;
  vec_t tbl[7];

  task automatic random_segment(input int ncyc);
    int unsigned len;
    logic [AW-1:0] wmin, wmax, rmin, rmax, m_wa, m_ra;
    bit w_act, w_first, r_cmd, r_wait, w_pend, r_pend, last_rd, w_end, r_end, wfl, rfl, idle;
    int left;
    len  = $urandom_range(1, 20);
    wmin = AW'($urandom_range(0, 300)); wmax = wmin + AW'($urandom_range(0, 150));
    rmin = AW'($urandom_range(0, 300)); rmax = rmin + AW'($urandom_range(0, 150));
    burst_len = LW'(len); init_done = 1'b1;
    wr_minaddr = wmin; wr_maxaddr = wmax; rd_minaddr = rmin; rd_maxaddr = rmax;
    wr_fifo_used = 10'd500; rd_fifo_used = 10'd0;
    do_reset();
    m_wa = '0; m_ra = '0; w_act = 0; w_first = 0; r_cmd = 0; r_wait = 0;
    w_pend = 0; r_pend = 0; last_rd = 1; left = 0;
    for (int c = 0; c < ncyc; c++) begin
      idle = !w_act && !r_cmd && !r_wait;
      chk("rnd_wreq", 32'(local_write_req), 32'(w_act));
      chk("rnd_rreq", 32'(local_read_req), 32'(r_cmd));
      chk("rnd_busy", 32'(busy), 32'(!idle));
      chk("rnd_bb", 32'(local_burstbegin), 32'((w_act && w_first) || r_cmd));
      if (!idle) begin
        chk("rnd_addr", 32'(local_address), 32'(w_act ? m_wa : m_ra));
        chk("rnd_size", 32'(local_size), len);
      end
      local_ready       = ($urandom_range(0, 3) != 0);
      local_rdata_valid = r_wait && ($urandom_range(0, 2) != 0);
      wr_load           = ($urandom_range(0, 19) == 0);
      rd_load           = ($urandom_range(0, 19) == 0);
      #1;
      chk("rnd_rden", 32'(wr_fifo_rden), 32'(w_act && local_ready));
      chk("rnd_wren", 32'(rd_fifo_wren), 32'(local_rdata_valid));
      // Model the clock edge.
      w_end = 0; r_end = 0; wfl = w_act; rfl = r_cmd || r_wait;
      if (w_act) begin
        if (local_ready) begin
          w_first = 0; left--;
          if (left == 0) begin w_act = 0; w_end = 1; end
        end
      end else if (r_cmd) begin
        if (local_ready) begin r_cmd = 0; r_wait = 1; left = int'(len); end
      end else if (r_wait) begin
        if (local_rdata_valid) begin
          left--;
          if (left == 0) begin r_wait = 0; r_end = 1; end
        end
      end else if (last_rd) begin
        w_act = 1; w_first = 1; left = int'(len); last_rd = 0;
      end else begin
        r_cmd = 1; last_rd = 1;
      end
      w_pend = w_pend || wr_load;
      r_pend = r_pend || rd_load;
      if (w_end) begin m_wa = w_pend ? wmin : adv(m_wa, wmin, wmax, len); w_pend = 0; end
      else if (w_pend && !wfl) begin m_wa = wmin; w_pend = 0; end
      if (r_end) begin m_ra = r_pend ? rmin : adv(m_ra, rmin, rmax, len); r_pend = 0; end
      else if (r_pend && !rfl) begin m_ra = rmin; r_pend = 0; end
      @(negedge clk);
    end
    wr_load = 1'b0; rd_load = 1'b0; local_rdata_valid = 1'b0;
  endtask

  initial begin
    int reqs;
    rst = 1'b1; init_done = 1'b0; burst_len = '0;
    wr_minaddr = '0; wr_maxaddr = 24'd1024; rd_minaddr = '0; rd_maxaddr = 24'd1024;
    wr_load = 1'b0; rd_load = 1'b0; wr_fifo_used = '0; rd_fifo_used = '0;
    local_ready = 1'b0; local_rdata_valid = 1'b0;

    // Eligibility table: one idle cycle after reset, then the expected grant.
    tbl[0] = '{1'b0, 7'd64, 10'd100, 10'd0,   1'b0, 1'b0};
    tbl[1] = '{1'b1, 7'd0,  10'd100, 10'd0,   1'b0, 1'b0};
    tbl[2] = '{1'b1, 7'd64, 10'd64,  10'd512, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 7'd64, 10'd63,  10'd448, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 7'd64, 10'd63,  10'd449, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 7'd64, 10'd100, 10'd0,   1'b1, 1'b0};
    tbl[6] = '{1'b1, 7'd1,  10'd0,   10'd511, 1'b0, 1'b1};
    foreach (tbl[i]) begin
      do_reset();
      chk_all_zero("reset");
      init_done = tbl[i].init; burst_len = tbl[i].len;
      wr_fifo_used = tbl[i].wu; rd_fifo_used = tbl[i].ru;
      @(negedge clk);
      chk("tbl_wreq", 32'(local_write_req), 32'(tbl[i].ew));
      chk("tbl_rreq", 32'(local_read_req), 32'(tbl[i].er));
      chk("tbl_bb", 32'(local_burstbegin), 32'(tbl[i].ew | tbl[i].er));
      chk("tbl_size", 32'(local_size), (tbl[i].ew | tbl[i].er) ? 32'(tbl[i].len) : 0);
    end

    // No calibration: no requests ever.
    do_reset();
    init_done = 1'b0; burst_len = 7'd64; wr_fifo_used = 10'd100; rd_fifo_used = 10'd0;
    reqs = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (local_write_req || local_read_req || local_burstbegin) reqs++;
    end
    chk("noinit_reqs", 32'(reqs), 0);

    // Write-only bursts at full readiness, window 0..1024.
    do_reset();
    init_done = 1'b1; burst_len = 7'd64; wr_fifo_used = 10'd64; rd_fifo_used = 10'd512;
    wr_minaddr = '0; wr_maxaddr = 24'd1024;
    run_wr_burst(0, 0);
    chk("wr1_beats", 32'(b_beats), 64);
    chk("wr1_bb", 32'(b_bb), 1);
    chk("wr1_late_bb", 32'(b_late_bb), 0);
    chk("wr1_addr", 32'(b_addr), 0);
    chk("wr1_unstable", 32'(b_unstable), 0);
    run_wr_burst(0, 0);
    chk("wr2_addr", 32'(b_addr), 64);

    // Ready toggling during a write burst.
    do_reset();
    run_wr_burst(1, 0);
    chk("tog_beats", 32'(b_beats), 64);
    chk("tog_bb", 32'(b_bb), 1);
    chk("tog_late_bb", 32'(b_late_bb), 0);
    chk("tog_unstable", 32'(b_unstable), 0);

    // Wrap through 0..1024 and back to 0.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      run_wr_burst(0, 0);
      chk("wrap_addr", 32'(b_addr), 32'((k * 64) % 1024));
      chk("wrap_beats", 32'(b_beats), 64);
    end

    // Window smaller than two bursts: every burst starts at minaddr.
    wr_maxaddr = 24'd100;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run_wr_burst(0, 0);
      chk("small_win_addr", 32'(b_addr), 0);
    end

    // Load mid-burst: burst completes, next burst rewinds instead of advancing.
    wr_minaddr = 24'd128; wr_maxaddr = 24'd1024;
    do_reset();
    run_wr_burst(0, 1);
    chk("load_addr0", 32'(b_addr), 0);
    chk("load_beats", 32'(b_beats), 64);
    run_wr_burst(0, 0);
    chk("load_next_addr", 32'(b_addr), 128);

    // Reset mid-burst: everything idle on the next cycle.
    do_reset();
    run_wr_burst(0, 2);
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;

    // Randomized alternating traffic against the burst-level model.
    for (int s = 0; s < 4; s++) random_segment(500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
